regfile_sb: RTL and testbench

Parametrised register file with a write-to-read bypass and a per-register pending-write scoreboard. It replaces the fixed 32x32, two-read-port register file in the decode stage of the pipelined core. A sequential clear sweep zeroes the storage, so the array can map to RAM instead of one flop per bit. Hazard logic reads the scoreboard to stall on operands whose producer has not yet reached writeback.

---
 rtl/regfile_sb.sv | 129 ++++++++++++
 tb/tb_regfile_sb.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// regfile_sb : register file with write bypass, pending-write scoreboard and
//              a sequential clear sweep.            Revision: 1.0
// ============================================================================
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = $clog2(NREGS),
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [AW-1:0]               wr_addr,
    input  logic [XLEN-1:0]             wr_data,
    input  logic                        issue_en,
    input  logic [AW-1:0]               issue_addr,
    input  logic                        clr_req,
    input  logic [NREAD*AW-1:0]         rd_addr,
    output logic [NREAD*XLEN-1:0]       rd_data,
    output logic [NREAD-1:0]            rd_busy,
    output logic [$clog2(NREGS+1)-1:0]  pend_cnt,
    output logic                        ready
);

    localparam int          c_pw       = $clog2(NREGS + 1);
    localparam logic        c_zr       = (ZERO_REG != 0);
    localparam logic [AW:0] c_last     = (AW + 1)'(NREGS - 1);
    localparam logic [0:0]  c_st_clear = 1'b0;
    localparam logic [0:0]  c_st_ready = 1'b1;

    logic [0:0]       r_state;
    logic [AW:0]      r_idx;
    logic [NREGS-1:0] r_busy;
    logic [c_pw-1:0]  r_pend;
    logic             r_ready;
    logic [XLEN-1:0]  r_mem [NREGS];

    logic             w_wq;
    logic             w_iq;
    logic             w_inc;
    logic             w_dec;
    logic [NREGS-1:0] w_busy_nxt;

    assign w_wq = (r_state == c_st_ready) && wr_en && !(c_zr && (wr_addr == '0));
    assign w_iq = (r_state == c_st_ready) && issue_en && !(c_zr && (issue_addr == '0));

    // A same-address issue keeps the bit set, so the write then does not decrement.
    assign w_inc = w_iq && !r_busy[issue_addr];
    assign w_dec = w_wq && r_busy[wr_addr] && !(w_iq && (issue_addr == wr_addr));

    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wq) w_busy_nxt[wr_addr] = 1'b0;
        if (w_iq) w_busy_nxt[issue_addr] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= c_st_clear;
            r_idx   <= '0;
            r_busy  <= '0;
            r_pend  <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                c_st_clear: begin
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == c_last) begin
                        r_state <= c_st_ready;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    if (clr_req) begin
                        r_state <= c_st_clear;
                        r_idx   <= '0;
                        r_busy  <= '0;
                        r_pend  <= '0;
                        r_ready <= 1'b0;
                    end else begin
                        r_busy <= w_busy_nxt;
                        r_pend <= r_pend + c_pw'(w_inc) - c_pw'(w_dec);
                    end
                end
            endcase
        end
    end

    // Storage has no reset so it can map onto a RAM; the sweep zeroes it instead.
    always_ff @(posedge clock) begin
        if (reset) begin
            if (r_state == c_st_clear)
                r_mem[r_idx[AW-1:0]] <= '0;
            else if (w_wq && !clr_req)
                r_mem[wr_addr] <= wr_data;
        end
    end

    for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
        logic [AW-1:0]   w_a;
        logic [XLEN-1:0] w_data;
        logic            w_busy;

        assign w_a = rd_addr[gi*AW +: AW];

        always_comb begin
            w_data = r_mem[w_a];
            w_busy = r_busy[w_a];
            if (!r_ready || (c_zr && (w_a == '0))) begin
                w_data = '0;
                w_busy = 1'b0;
            end else if (w_wq && (wr_addr == w_a)) begin
                w_data = wr_data;
                w_busy = 1'b0;
            end
        end

        assign rd_data[gi*XLEN +: XLEN] = w_data;
        assign rd_busy[gi]              = w_busy;
    end

    assign pend_cnt = r_pend;
    assign ready    = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// tb_regfile_sb : random and directed checks of two regfile_sb configurations
//                 against a behavioural model.      Revision: 1.0
// ============================================================================
module tb_regfile_sb;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic        issue_en = 1'b0;
    logic        clr_req = 1'b0;
    logic [4:0]  wa = '0;
    logic [4:0]  ia = '0;
    logic [31:0] wd = '0;
    logic [4:0]  ra [3];

    logic [63:0] rd_data_a;
    logic [1:0]  rd_busy_a;
    logic [5:0]  pend_a;
    logic        ready_a;
    logic [95:0] rd_data_b;
    logic [2:0]  rd_busy_b;
    logic [4:0]  pend_b;
    logic        ready_b;

    int n_vec = 0;
    int n_err = 0;
    bit armed = 0;

    // Reference state, index 0: 32 regs / zero reg, index 1: 16 regs / no zero reg
    logic [31:0] mm   [2][32];
    bit          mb   [2][32];
    bit          mrdy [2];
    int          mleft[2];

    always #5 clock = ~clock;

    regfile_sb u_dut_a (
        .clock      (clock),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wa),
        .wr_data    (wd),
        .issue_en   (issue_en),
        .issue_addr (ia),
        .clr_req    (clr_req),
        .rd_addr    ({ra[1], ra[0]}),
        .rd_data    (rd_data_a),
        .rd_busy    (rd_busy_a),
        .pend_cnt   (pend_a),
        .ready      (ready_a)
    );

    regfile_sb #(.NREGS(16), .NREAD(3), .ZERO_REG(0)) u_dut_b (
        .clock      (clock),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wa[3:0]),
        .wr_data    (wd),
        .issue_en   (issue_en),
        .issue_addr (ia[3:0]),
        .clr_req    (clr_req),
        .rd_addr    ({ra[2][3:0], ra[1][3:0], ra[0][3:0]}),
        .rd_data    (rd_data_b),
        .rd_busy    (rd_busy_b),
        .pend_cnt   (pend_b),
        .ready      (ready_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int nregs(input int k);
        return (k == 0) ? 32 : 16;
    endfunction

    function automatic int popcnt(input int k);
        int c = 0;
        for (int r = 0; r < nregs(k); r++) c += int'(mb[k][r]);
        return c;
    endfunction

    // {busy, data} a read port should show this cycle
    function automatic logic [32:0] exp_read(input int k, input int a);
        int  n  = nregs(k);
        bit  zr = (k == 0);
        int  aa = a % n;
        int  w  = int'(wa) % n;
        if (!mrdy[k]) return '0;
        if (zr && aa == 0) return '0;
        if (wr_en && !(zr && w == 0) && w == aa) return {1'b0, wd};
        return {mb[k][aa], mm[k][aa]};
    endfunction

    task automatic check_all();
        logic [32:0] e;
        chk("ready_a", 64'(ready_a), 64'(mrdy[0]));
        chk("pend_a",  64'(pend_a),  64'(popcnt(0)));
        chk("ready_b", 64'(ready_b), 64'(mrdy[1]));
        chk("pend_b",  64'(pend_b),  64'(popcnt(1)));
        for (int p = 0; p < 2; p++) begin
            e = exp_read(0, int'(ra[p]));
            chk($sformatf("rd_data_a%0d@%0d", p, ra[p]), 64'(rd_data_a[p*32 +: 32]), 64'(e[31:0]));
            chk($sformatf("rd_busy_a%0d@%0d", p, ra[p]), 64'(rd_busy_a[p]), 64'(e[32]));
        end
        for (int p = 0; p < 3; p++) begin
            e = exp_read(1, int'(ra[p]));
            chk($sformatf("rd_data_b%0d@%0d", p, ra[p] % 16), 64'(rd_data_b[p*32 +: 32]), 64'(e[31:0]));
            chk($sformatf("rd_busy_b%0d@%0d", p, ra[p] % 16), 64'(rd_busy_b[p]), 64'(e[32]));
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            int n  = nregs(k);
            bit zr = (k == 0);
            int w  = int'(wa) % n;
            int i  = int'(ia) % n;
            if (!reset) begin
                mrdy[k]  = 0;
                mleft[k] = n;
                for (int r = 0; r < 32; r++) mb[k][r] = 0;
            end else if (!mrdy[k]) begin
                mm[k][n - mleft[k]] = '0;
                mleft[k]--;
                if (mleft[k] == 0) mrdy[k] = 1;
            end else if (clr_req) begin
                mrdy[k]  = 0;
                mleft[k] = n;
                for (int r = 0; r < 32; r++) mb[k][r] = 0;
            end else begin
                if (wr_en && !(zr && w == 0)) begin
                    mm[k][w] = wd;
                    mb[k][w] = 0;
                end
                if (issue_en && !(zr && i == 0)) mb[k][i] = 1;
            end
        end
    endtask

    // Inputs are set before the call; outputs are checked on the falling edge.
    task automatic step();
        @(negedge clock);
        if (armed) check_all();
        @(posedge clock);
        model_update();
        if (!reset) armed = 1;
        #1;
    endtask

    task automatic steps(input int n);
        for (int c = 0; c < n; c++) step();
    endtask

    task automatic sweep_check(input string tag);
        steps(31);
        chk({tag, "_ready_low"}, 64'(ready_a), 64'd0);
        step();
        chk({tag, "_ready_high"}, 64'(ready_a), 64'd1);
    endtask

    initial begin
        for (int p = 0; p < 3; p++) ra[p] = '0;
        for (int k = 0; k < 2; k++) begin
            mrdy[k] = 0;
            mleft[k] = nregs(k);
            for (int r = 0; r < 32; r++) begin
                mm[k][r] = '0;
                mb[k][r] = 0;
            end
        end

        // Reset, then sweep lengths of both configurations
        steps(2);
        reset = 1'b1;
        steps(15);
        chk("b_ready_low", 64'(ready_b), 64'd0);
        step();
        chk("b_ready_high", 64'(ready_b), 64'd1);
        steps(15);
        chk("a_ready_low", 64'(ready_a), 64'd0);
        step();
        chk("a_ready_high", 64'(ready_a), 64'd1);
        chk("pend_after_sweep", 64'(pend_a), 64'd0);
        for (int r = 0; r < 32; r++) begin
            ra[0] = 5'(r); ra[1] = 5'(31 - r); ra[2] = 5'(r + 3);
            step();
        end

        // Bypass and array write
        ra[0] = 5'd5; wr_en = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
        #2 chk("bypass_5", 64'(rd_data_a[31:0]), 64'hDEADBEEF);
        step();
        wr_en = 1'b0;
        #2 chk("array_5", 64'(rd_data_a[31:0]), 64'hDEADBEEF);
        step();
        wr_en = 1'b1; wa = 5'd0; wd = 32'h1234;
        step();
        wr_en = 1'b0; ra[0] = 5'd0;
        #2 chk("zero_reg_a", 64'(rd_data_a[31:0]), 64'd0);
        chk("reg0_writable_b", 64'(rd_data_b[31:0]), 64'h1234);
        step();

        // Scoreboard set and clear
        issue_en = 1'b1; ia = 5'd7;
        step();
        issue_en = 1'b0; ra[0] = 5'd7;
        #2 chk("busy_7", 64'(rd_busy_a[0]), 64'd1);
        chk("pend_1", 64'(pend_a), 64'd1);
        step();
        wr_en = 1'b1; wa = 5'd7; wd = 32'h55;
        #2 chk("clear_bypass_busy", 64'(rd_busy_a[0]), 64'd0);
        chk("clear_bypass_data", 64'(rd_data_a[31:0]), 64'h55);
        step();
        wr_en = 1'b0;
        chk("pend_0", 64'(pend_a), 64'd0);

        // Same-cycle issue and write: new producer wins
        issue_en = 1'b1; ia = 5'd9;
        step();
        wr_en = 1'b1; wa = 5'd9; wd = 32'h99;
        step();
        wr_en = 1'b0;
        chk("pend_same_cycle", 64'(pend_a), 64'd1);
        ra[0] = 5'd9;
        #2 chk("busy_9_kept", 64'(rd_busy_a[0]), 64'd1);
        ia = 5'd10;
        step();
        ia = 5'd11;
        step();
        issue_en = 1'b0;
        chk("pend_3", 64'(pend_a), 64'd3);

        // Flush sweep with busy, nonzero registers and a lost write
        wr_en = 1'b1; wa = 5'd3; wd = 32'hA3;
        step();
        wa = 5'd4; wd = 32'hA4;
        step();
        wr_en = 1'b0; issue_en = 1'b1; ia = 5'd3;
        step();
        ia = 5'd4;
        step();
        issue_en = 1'b0; clr_req = 1'b1;
        step();
        clr_req = 1'b0; wr_en = 1'b1; wa = 5'd12; wd = 32'hBAD;
        step();
        wr_en = 1'b0;
        steps(30);
        chk("flush_ready_low", 64'(ready_a), 64'd0);
        step();
        chk("flush_ready_high", 64'(ready_a), 64'd1);
        chk("flush_pend", 64'(pend_a), 64'd0);
        ra[0] = 5'd12; ra[1] = 5'd3;
        #2 chk("lost_write_12", 64'(rd_data_a[31:0]), 64'd0);
        chk("flushed_3", 64'(rd_data_a[63:32]), 64'd0);
        for (int r = 0; r < 32; r++) begin
            ra[0] = 5'(r); ra[1] = 5'(r ^ 1); ra[2] = 5'(r ^ 2);
            step();
        end

        // Reset in mid-sweep restarts it
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        steps(17);
        reset = 1'b0;
        step();
        reset = 1'b1;
        sweep_check("restart");

        // Random traffic, addresses biased toward a small set to create hazards
        for (int c = 0; c < 1500; c++) begin
            reset    = ($urandom_range(0, 299) != 0);
            clr_req  = ($urandom_range(0, 79) == 0);
            wr_en    = $urandom_range(0, 1) == 1;
            issue_en = $urandom_range(0, 1) == 1;
            wa = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            ia = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            wd = $urandom;
            for (int p = 0; p < 3; p++)
                ra[p] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
